wb_arbiter: RTL and testbench

Round-robin Wishbone arbiter that shares one downstream Wishbone slave (output ports, peripheral registers) between `NUM_MASTERS` upstream masters. It grants ownership per bus cycle (`cyc`), muxes the owner's request onto the slave, and routes `ack`/`err` back to the owner only. A watchdog terminates stalled strobes with `err`. It sits between the masters and a single slave or address decoder.

---
 rtl/wb_arbiter.sv | 132 +++++++++++++
 tb/tb_wb_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: several masters share one slave, one bus cycle at a time.
// A watchdog terminates a strobe the slave leaves unanswered for too long by returning err.
module wb_arbiter #(
   parameter int NUM_MASTERS  = 2,
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int SELECT_WIDTH = DATA_WIDTH / 8,
   parameter int TIMEOUT      = 15
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_MASTERS-1:0]               m_cyc_i,
   input  logic [NUM_MASTERS-1:0]               m_stb_i,
   input  logic [NUM_MASTERS-1:0]               m_we_i,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    m_adr_i,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_dat_i,
   input  logic [NUM_MASTERS*SELECT_WIDTH-1:0]  m_sel_i,
   output logic [DATA_WIDTH-1:0]                m_dat_o,
   output logic [NUM_MASTERS-1:0]               m_ack_o,
   output logic [NUM_MASTERS-1:0]               m_err_o,
   output logic                                 s_cyc_o,
   output logic                                 s_stb_o,
   output logic                                 s_we_o,
   output logic [ADDR_WIDTH-1:0]                s_adr_o,
   output logic [DATA_WIDTH-1:0]                s_dat_o,
   output logic [SELECT_WIDTH-1:0]              s_sel_o,
   input  logic [DATA_WIDTH-1:0]                s_dat_i,
   input  logic                                 s_ack_i,
   input  logic                                 s_err_i,
   output logic [NUM_MASTERS-1:0]               grant_o,
   output logic                                 busy_o
);

   localparam int RR_W = $clog2(NUM_MASTERS);
   localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

   typedef enum logic {IDLE, OWNED} state_t;

   state_t                 state, state_nxt;
   logic [NUM_MASTERS-1:0] grant, grant_nxt;
   logic [RR_W-1:0]        rr, rr_nxt;
   logic [WD_W-1:0]        wd, wd_nxt;
   logic [RR_W-1:0]        owner;
   logic [RR_W-1:0]        pick;
   logic                   busy, owner_cyc, owner_stb, waiting, wd_fire;

   // Index of the current owner, decoded from the one-hot grant.
   always_comb begin
      owner = '0;
      for (int i = 0; i < NUM_MASTERS; i++)
         if (grant[i]) owner = RR_W'(i);
   end

   // First requester at or after rr, wrapping.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      int  idx;
      logic found;
      pick  = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         idx = (int'(rr) + k) % NUM_MASTERS;
         if (!found && m_cyc_i[idx]) begin
            pick  = RR_W'(idx);
            found = 1'b1;
         end
      end
   end

   assign busy      = (state == OWNED);
   assign owner_cyc = m_cyc_i[owner];
   assign owner_stb = m_stb_i[owner];
   assign waiting   = busy & owner_cyc & owner_stb & ~s_ack_i & ~s_err_i;
   assign wd_fire   = (TIMEOUT != 0) && (wd == WD_MAX) && waiting;

   assign s_cyc_o = busy & owner_cyc;
   assign s_stb_o = busy & owner_stb;
   assign s_we_o  = busy & m_we_i[owner];
   assign s_adr_o = busy ? m_adr_i[owner*ADDR_WIDTH +: ADDR_WIDTH]     : '0;
   assign s_dat_o = busy ? m_dat_i[owner*DATA_WIDTH +: DATA_WIDTH]     : '0;
   assign s_sel_o = busy ? m_sel_i[owner*SELECT_WIDTH +: SELECT_WIDTH] : '0;
   assign m_dat_o = busy ? s_dat_i : '0;

   // grant is zero in IDLE, so these route only to the owner.
   assign m_ack_o = (busy && s_ack_i && owner_cyc && owner_stb) ? grant : '0;
   assign m_err_o = (busy && (s_err_i || wd_fire) && owner_cyc && owner_stb) ? grant : '0;
   assign grant_o = grant;
   assign busy_o  = busy;

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      rr_nxt    = rr;
      wd_nxt    = '0;
      case (state)
         IDLE: begin
            if (|m_cyc_i) begin
               state_nxt = OWNED;
               grant_nxt = NUM_MASTERS'(1) << pick;
            end
         end
         OWNED: begin
            if (!owner_cyc) begin
               state_nxt = IDLE;
               grant_nxt = '0;
               rr_nxt    = (owner == RR_W'(NUM_MASTERS - 1)) ? '0 : owner + RR_W'(1);
            end else if (waiting && !wd_fire && wd < WD_MAX) begin
               wd_nxt = wd + WD_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         grant <= '0;
         rr    <= '0;
         wd    <= '0;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         rr    <= rr_nxt;
         wd    <= wd_nxt;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// A second instance with the watchdog disabled shares all inputs.
module tb_wb_arbiter;
   localparam int N  = 2;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int SW = 4;
   localparam int TO = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    m_cyc = '0, m_stb = '0, m_we = '0;
   logic [N*AW-1:0] m_adr = '0;
   logic [N*DW-1:0] m_dat = '0;
   logic [N*SW-1:0] m_sel = '0;
   logic            auto_ack = 1'b0, ack_drv = 1'b0, s_err = 1'b0;
   logic [DW-1:0]   slave_reg;

   logic [DW-1:0] m_dat_o, s_dat_o, m_dat_z, s_dat_z, s_dat_i;
   logic [AW-1:0] s_adr_o, s_adr_z;
   logic [SW-1:0] s_sel_o, s_sel_z;
   logic [N-1:0]  m_ack_o, m_err_o, grant_o, m_ack_z, m_err_z, grant_z;
   logic          s_cyc_o, s_stb_o, s_we_o, busy_o, s_cyc_z, s_stb_z, s_we_z, busy_z, s_ack_i;

   int vectors = 0;
   int miscompares = 0;

   // Behavioural model: owner index (-1 when idle), next-preferred master, consecutive stall run.
   int mdl_owner, mdl_rr, mdl_run;

   always #5 clk = ~clk;

   // Byte-select output-port slave; either acks every strobe at once or follows ack_drv.
   assign s_dat_i = slave_reg;
   assign s_ack_i = auto_ack ? (s_cyc_o & s_stb_o) : ack_drv;
   always @(posedge clk) begin
      if (!rst_n) slave_reg <= '0;
      else if (s_cyc_o & s_stb_o & s_we_o & s_ack_i)
         for (int b = 0; b < SW; b++)
            if (s_sel_o[b]) slave_reg[b*8 +: 8] <= s_dat_o[b*8 +: 8];
   end

   wb_arbiter #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
      .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_dat_o(m_dat_o),
      .m_ack_o(m_ack_o), .m_err_o(m_err_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
      .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err), .grant_o(grant_o), .busy_o(busy_o));

   wb_arbiter #(.NUM_MASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .TIMEOUT(0)) dut_nowd (
      .clk(clk), .rst_n(rst_n), .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
      .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_dat_o(m_dat_z),
      .m_ack_o(m_ack_z), .m_err_o(m_err_z), .s_cyc_o(s_cyc_z), .s_stb_o(s_stb_z),
      .s_we_o(s_we_z), .s_adr_o(s_adr_z), .s_dat_o(s_dat_z), .s_sel_o(s_sel_z),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err), .grant_o(grant_z), .busy_o(busy_z));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      m_cyc = '0; m_stb = '0; m_we = '0; ack_drv = 1'b0; s_err = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   function automatic logic mdl_waiting();
      if (mdl_owner < 0) return 1'b0;
      return m_cyc[mdl_owner] & m_stb[mdl_owner] & ~s_ack_i & ~s_err;
   endfunction

   // Advance the model across one clock edge using the inputs currently applied.
   task automatic model_step();
      if (!rst_n) begin
         mdl_owner = -1; mdl_rr = 0; mdl_run = 0;
      end else if (mdl_owner < 0) begin
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (mdl_rr + k) % N;
            if (m_cyc[idx]) begin
               mdl_owner = idx;
               break;
            end
         end
         mdl_run = 0;
      end else if (!m_cyc[mdl_owner]) begin
         mdl_rr = (mdl_owner + 1) % N;
         mdl_owner = -1;
         mdl_run = 0;
      end else begin
         mdl_run = mdl_waiting() ? mdl_run + 1 : 0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; m_cyc = 2'b11; m_stb = 2'b11; auto_ack = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick(); #1;
         vectors++;
         if (grant_o !== 2'b00 || s_cyc_o !== 1'b0 || busy_o !== 1'b0 || m_ack_o !== 2'b00 || m_err_o !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_hold[%0d]: grant=%b s_cyc=%b busy=%b ack=%b err=%b, expected all 0",
                     c, grant_o, s_cyc_o, busy_o, m_ack_o, m_err_o);
         end
      end
      rst_n = 1'b1; #1;
      vectors++;
      if (grant_o !== 2'b00) begin
         miscompares++; $display("FAIL reset_release_idle: grant=%b expected 00", grant_o);
      end
      tick(); #1;
      vectors++;
      if (grant_o !== 2'b01 || s_cyc_o !== 1'b1 || busy_o !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_first_grant: grant=%b s_cyc=%b busy=%b expected 01 1 1", grant_o, s_cyc_o, busy_o);
      end
      m_cyc = '0; m_stb = '0;
      tick(); tick();
   endtask

   task automatic test_single_write();
      do_reset();
      auto_ack = 1'b1;
      m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b10;
      m_adr[AW +: AW] = 32'h0000_0100; m_dat[DW +: DW] = 32'hDEAD_BEEF; m_sel[SW +: SW] = 4'b0011;
      #1;
      vectors++;
      if (grant_o !== 2'b00) begin
         miscompares++; $display("FAIL write_latency: grant=%b expected 00 before edge", grant_o);
      end
      tick(); #1;
      vectors++;
      if (grant_o !== 2'b10 || m_ack_o !== 2'b10) begin
         miscompares++; $display("FAIL write_grant_ack: grant=%b ack=%b expected 10 10", grant_o, m_ack_o);
      end
      vectors++;
      if (s_we_o !== 1'b1 || s_adr_o !== 32'h100 || s_dat_o !== 32'hDEAD_BEEF || s_sel_o !== 4'b0011) begin
         miscompares++;
         $display("FAIL write_mux: we=%b adr=%h dat=%h sel=%b expected 1 00000100 deadbeef 0011",
                  s_we_o, s_adr_o, s_dat_o, s_sel_o);
      end
      tick();
      m_we = 2'b00; #1;
      vectors++;
      if (slave_reg !== 32'h0000_BEEF || m_dat_o !== 32'h0000_BEEF) begin
         miscompares++;
         $display("FAIL write_result: reg=%h m_dat_o=%h expected 0000beef", slave_reg, m_dat_o);
      end
      m_cyc = '0; m_stb = '0;
      tick(); tick();
   endtask

   task automatic test_round_robin();
      do_reset();
      auto_ack = 1'b1;
      m_cyc = 2'b11; m_stb = 2'b11;
      tick(); #1;
      vectors++;
      if (grant_o !== 2'b01 || m_ack_o !== 2'b01) begin
         miscompares++; $display("FAIL rr_first: grant=%b ack=%b expected 01 01", grant_o, m_ack_o);
      end
      m_cyc = 2'b10; m_stb = 2'b10;
      tick(); #1;
      vectors++;
      if (grant_o !== 2'b00 || s_cyc_o !== 1'b0) begin
         miscompares++; $display("FAIL rr_gap: grant=%b s_cyc=%b expected 00 0", grant_o, s_cyc_o);
      end
      tick(); #1;
      vectors++;
      if (grant_o !== 2'b10) begin
         miscompares++; $display("FAIL rr_second: grant=%b expected 10", grant_o);
      end
      m_cyc = 2'b00; m_stb = 2'b00;
      tick();
      m_cyc = 2'b11; m_stb = 2'b11;
      tick(); #1;
      vectors++;
      if (grant_o !== 2'b01) begin
         miscompares++; $display("FAIL rr_wrap: grant=%b expected 01", grant_o);
      end
      m_cyc = '0; m_stb = '0;
      tick(); tick();
   endtask

   task automatic test_held_cycle();
      int ack_cnt;
      ack_cnt = 0;
      do_reset();
      auto_ack = 1'b0;
      m_cyc = 2'b11; m_stb = 2'b11;
      tick();
      for (int s = 0; s < 3; s++) begin
         ack_drv = 1'b0; #1;
         vectors++;
         if (m_ack_o !== 2'b00 || grant_o !== 2'b01) begin
            miscompares++; $display("FAIL held_stall[%0d]: ack=%b grant=%b expected 00 01", s, m_ack_o, grant_o);
         end
         tick();
         ack_drv = 1'b1; #1;
         vectors++;
         if (m_ack_o !== 2'b01) begin
            miscompares++; $display("FAIL held_ack[%0d]: ack=%b expected 01", s, m_ack_o);
         end
         if (m_ack_o[0]) ack_cnt++;
         tick();
      end
      vectors++;
      if (ack_cnt != 3) begin
         miscompares++; $display("FAIL held_ack_count: got %0d expected 3", ack_cnt);
      end
      ack_drv = 1'b0; m_cyc = 2'b10; m_stb = 2'b10;
      tick(); #1;
      vectors++;
      if (grant_o !== 2'b00) begin
         miscompares++; $display("FAIL held_gap: grant=%b expected 00", grant_o);
      end
      tick(); #1;
      vectors++;
      if (grant_o !== 2'b10) begin
         miscompares++; $display("FAIL held_handover: grant=%b expected 10", grant_o);
      end
      m_cyc = '0; m_stb = '0;
      tick(); tick();
   endtask

   task automatic test_watchdog();
      logic exp_err;
      do_reset();
      auto_ack = 1'b0; ack_drv = 1'b0;
      m_cyc = 2'b01; m_stb = 2'b01;
      tick();
      for (int c = 1; c <= 10; c++) begin
         #1;
         exp_err = (c == 5) || (c == 10);
         vectors++;
         if (m_err_o !== {1'b0, exp_err}) begin
            miscompares++; $display("FAIL wd_cycle[%0d]: err=%b expected %b", c, m_err_o, {1'b0, exp_err});
         end
         vectors++;
         if (m_err_z !== 2'b00) begin
            miscompares++; $display("FAIL wd_disabled[%0d]: err=%b expected 00", c, m_err_z);
         end
         tick();
      end
      s_err = 1'b1; ack_drv = 1'b1; #1;
      vectors++;
      if (m_err_o !== 2'b01 || m_ack_o !== 2'b01 || m_err_z !== 2'b01) begin
         miscompares++;
         $display("FAIL wd_ack_and_err: err=%b ack=%b err_nowd=%b expected 01 01 01", m_err_o, m_ack_o, m_err_z);
      end
      tick();
      s_err = 1'b0; ack_drv = 1'b0; m_cyc = '0; m_stb = '0;
      tick(); tick();
   endtask

   task automatic test_mid_reset();
      do_reset();
      auto_ack = 1'b1;
      m_cyc = 2'b01; m_stb = 2'b01;
      tick();
      m_cyc = 2'b00; m_stb = 2'b00;
      tick();
      auto_ack = 1'b0; ack_drv = 1'b0;
      m_cyc = 2'b10; m_stb = 2'b10;
      tick(); tick();
      rst_n = 1'b0; #1;
      vectors++;
      if (grant_o !== 2'b10 || m_err_o !== 2'b00 || m_ack_o !== 2'b00) begin
         miscompares++;
         $display("FAIL mid_reset_before: grant=%b err=%b ack=%b expected 10 00 00", grant_o, m_err_o, m_ack_o);
      end
      tick();
      rst_n = 1'b1; ack_drv = 1'b1; m_cyc = 2'b11; m_stb = 2'b11; #1;
      vectors++;
      if (s_cyc_o !== 1'b0 || grant_o !== 2'b00 || m_ack_o !== 2'b00 || m_err_o !== 2'b00) begin
         miscompares++;
         $display("FAIL mid_reset_after: s_cyc=%b grant=%b ack=%b err=%b expected 0 00 00 00",
                  s_cyc_o, grant_o, m_ack_o, m_err_o);
      end
      tick(); #1;
      vectors++;
      if (grant_o !== 2'b01) begin
         miscompares++; $display("FAIL mid_reset_rr: grant=%b expected 01", grant_o);
      end
      ack_drv = 1'b0; m_cyc = '0; m_stb = '0;
      tick(); tick();
   endtask

   task automatic test_random();
      logic [N-1:0]  exp_grant, exp_ack, exp_err, exp_err_nowd;
      logic          own_req, fire, exp_cyc, exp_stb, exp_we;
      logic [AW-1:0] exp_adr;
      logic [DW-1:0] exp_dat;
      logic [SW-1:0] exp_sel;
      do_reset();
      auto_ack = 1'b0;
      mdl_owner = -1; mdl_rr = 0; mdl_run = 0;
      for (int cyc_n = 0; cyc_n < 600; cyc_n++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(3) == 0) m_cyc[i] = ~m_cyc[i];
            m_stb[i] = ($urandom_range(3) != 0);
         end
         m_we    = N'($urandom);
         m_adr   = {$urandom, $urandom};
         m_dat   = {$urandom, $urandom};
         m_sel   = (N*SW)'($urandom);
         ack_drv = ($urandom_range(5) == 0);
         s_err   = ($urandom_range(19) == 0);
         rst_n   = ($urandom_range(63) != 0);
         #1;
         exp_grant = '0; exp_ack = '0; exp_err = '0; exp_err_nowd = '0;
         exp_cyc = 1'b0; exp_stb = 1'b0; exp_we = 1'b0; exp_adr = '0; exp_dat = '0; exp_sel = '0;
         if (mdl_owner >= 0) begin
            exp_grant = N'(1) << mdl_owner;
            own_req   = m_cyc[mdl_owner] & m_stb[mdl_owner];
            fire      = mdl_waiting() && ((mdl_run % (TO + 1)) == TO);
            exp_cyc   = m_cyc[mdl_owner];
            exp_stb   = m_stb[mdl_owner];
            exp_we    = m_we[mdl_owner];
            exp_adr   = m_adr[mdl_owner*AW +: AW];
            exp_dat   = m_dat[mdl_owner*DW +: DW];
            exp_sel   = m_sel[mdl_owner*SW +: SW];
            if (own_req && s_ack_i) exp_ack = exp_grant;
            if (own_req && (s_err || fire)) exp_err = exp_grant;
            if (own_req && s_err) exp_err_nowd = exp_grant;
         end
         vectors++;
         if (grant_o !== exp_grant || busy_o !== (mdl_owner >= 0) || s_cyc_o !== exp_cyc || s_stb_o !== exp_stb) begin
            miscompares++;
            $display("FAIL rand_ctrl[%0d]: grant=%b busy=%b cyc=%b stb=%b expected %b %b %b %b", cyc_n,
                     grant_o, busy_o, s_cyc_o, s_stb_o, exp_grant, (mdl_owner >= 0), exp_cyc, exp_stb);
         end
         vectors++;
         if (s_we_o !== exp_we || s_adr_o !== exp_adr || s_dat_o !== exp_dat || s_sel_o !== exp_sel) begin
            miscompares++;
            $display("FAIL rand_mux[%0d]: we=%b adr=%h dat=%h sel=%b expected %b %h %h %b", cyc_n,
                     s_we_o, s_adr_o, s_dat_o, s_sel_o, exp_we, exp_adr, exp_dat, exp_sel);
         end
         vectors++;
         if (m_ack_o !== exp_ack || m_err_o !== exp_err || m_err_z !== exp_err_nowd) begin
            miscompares++;
            $display("FAIL rand_resp[%0d]: ack=%b err=%b err_nowd=%b expected %b %b %b", cyc_n,
                     m_ack_o, m_err_o, m_err_z, exp_ack, exp_err, exp_err_nowd);
         end
         if (mdl_owner >= 0) begin
            vectors++;
            if (m_dat_o !== slave_reg) begin
               miscompares++; $display("FAIL rand_rdata[%0d]: m_dat_o=%h expected %h", cyc_n, m_dat_o, slave_reg);
            end
         end
         model_step();
         tick();
      end
      rst_n = 1'b1; m_cyc = '0; m_stb = '0; ack_drv = 1'b0; s_err = 1'b0;
      tick(); tick();
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_round_robin();
      test_held_cycle();
      test_watchdog();
      test_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "time limit exceeded");
   end
endmodule
